// File: rtl/hist_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : hist_ram_arbiter_if
//  Purpose  : Avalon-MM style requester bus for one port of the histogram
//             RAM arbiter (command, stall, read return).
//  Signals  : addr/read/write/writedata   requester -> arbiter
//             waitrequest                 arbiter -> requester (stall)
//             readdata/readdatavalid      arbiter -> requester (read return)
//  Modports : master = requester side, slave = arbiter side
//  Revision : 1.0  initial release
// ============================================================================
interface hist_ram_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  modport master (
    output addr, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  addr, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/hist_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hist_ram_arbiter
//  Purpose  : Shares one single-port histogram RAM between two requesters
//             (A = JTAG master, B = host channel). One command per cycle,
//             combinational grant, read data returned to the issuer after a
//             fixed RAM latency, saturating per-port grant counters.
//  Ports    : clk, rst_n          clock, async active-low reset
//             pri_fixed          0 = round-robin, 1 = port B strict priority
//             clr_stats          synchronous clear of cnt_a/cnt_b
//             a_bus, b_bus       requester buses (slave modport)
//             ram_addr/ram_data/ram_wren/ram_q   RAM interface
//             cnt_a, cnt_b       granted-command counters
//  Revision : 1.0  initial release
// ============================================================================
module hist_ram_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               pri_fixed,
  input  wire               clr_stats,
  hist_ram_arbiter_if.slave a_bus,
  hist_ram_arbiter_if.slave b_bus,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_data,
  output logic              ram_wren,
  input  wire  [DW-1:0]     ram_q,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  localparam logic c_PORT_A = 1'b0;
  localparam logic c_PORT_B = 1'b1;

  logic              r_last_grant;
  logic              w_req_a;
  logic              w_req_b;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_rd_issue;
  logic [RD_LAT-1:0] r_rd_vld;
  logic [RD_LAT-1:0] r_rd_own;
  logic [CNT_W-1:0]  r_cnt_a;
  logic [CNT_W-1:0]  r_cnt_b;

  // Arbitration: B wins when alone, under strict priority, or when A had
  // the previous grant; A wins every other requesting case.
  always_comb begin
    w_req_a = a_bus.read | a_bus.write;
    w_req_b = b_bus.read | b_bus.write;
    w_gnt_b = w_req_b & (~w_req_a | pri_fixed | (r_last_grant == c_PORT_A));
    w_gnt_a = w_req_a & ~w_gnt_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= c_PORT_B;
    end else if (w_gnt_a | w_gnt_b) begin
      r_last_grant <= w_gnt_b ? c_PORT_B : c_PORT_A;
    end
  end

  assign a_bus.waitrequest = w_req_a & ~w_gnt_a;
  assign b_bus.waitrequest = w_req_b & ~w_gnt_b;

  // RAM drive: port A's bus is parked on the RAM when nobody is granted.
  // A write has priority over a read asserted in the same command.
  always_comb begin
    ram_addr   = w_gnt_b ? b_bus.addr      : a_bus.addr;
    ram_data   = w_gnt_b ? b_bus.writedata : a_bus.writedata;
    ram_wren   = rst_n & ((w_gnt_a & a_bus.write) | (w_gnt_b & b_bus.write));
    w_rd_issue = (w_gnt_a & a_bus.read & ~a_bus.write)
               | (w_gnt_b & b_bus.read & ~b_bus.write);
  end

  // Read return tracker: {valid, owner} travels alongside the RAM pipeline
  // so the last stage lines up with ram_q.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_vld <= '0;
          r_rd_own <= '0;
        end else begin
          r_rd_vld <= w_rd_issue;
          r_rd_own <= w_gnt_b;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_vld <= '0;
          r_rd_own <= '0;
        end else begin
          r_rd_vld <= {r_rd_vld[RD_LAT-2:0], w_rd_issue};
          r_rd_own <= {r_rd_own[RD_LAT-2:0], w_gnt_b};
        end
      end
    end
  endgenerate

  assign a_bus.readdatavalid = r_rd_vld[RD_LAT-1] & (r_rd_own[RD_LAT-1] == c_PORT_A);
  assign b_bus.readdatavalid = r_rd_vld[RD_LAT-1] & (r_rd_own[RD_LAT-1] == c_PORT_B);
  assign a_bus.readdata      = ram_q;
  assign b_bus.readdata      = ram_q;

  // Saturating grant counters; clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (clr_stats) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_gnt_a && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + 1'b1;
      if (w_gnt_b && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;

endmodule
`default_nettype wire

// File: tb/tb_hist_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hist_ram_arbiter
//  Purpose  : Self-checking bench for hist_ram_arbiter. A behavioural RAM
//             with two-cycle latency sits on the RAM port; a transaction
//             level model (shadow memory + queue of pending read returns)
//             predicts grants, stalls, RAM drive, read returns and counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hist_ram_arbiter;
  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pri_fixed;
  logic             clr_stats;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_data;
  logic             ram_wren;
  logic [DW-1:0]    ram_q;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  hist_ram_arbiter_if #(.AW(AW), .DW(DW)) a_bus ();
  hist_ram_arbiter_if #(.AW(AW), .DW(DW)) b_bus ();

  hist_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pri_fixed(pri_fixed), .clr_stats(clr_stats),
    .a_bus(a_bus), .b_bus(b_bus),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  // Single-port RAM: input register on address, output register on data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
  end
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_addr_q <= ram_addr;
    ram_q      <= mem[ram_addr_q];
  end

  // ---------------- reference model ----------------
  typedef struct { int due; bit port; logic [DW-1:0] data; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            m_last;       // 1 = B held the previous grant
  int            m_cnt_a, m_cnt_b, cyc;
  int            n_checks = 0, n_pass = 0;

  bit            e_ga, e_gb, e_wa, e_wb, e_wren, e_rva, e_rvb;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_rdata;

  task automatic model_reset();
    pend.delete();
    m_cnt_a = 0; m_cnt_b = 0; m_last = 1'b1;
  endtask

  task automatic model_eval();
    bit ra, rb;
    ra = a_bus.read | a_bus.write;
    rb = b_bus.read | b_bus.write;
    e_ga = 0; e_gb = 0;
    if (ra && rb) begin
      if (pri_fixed || !m_last) e_gb = 1; else e_ga = 1;
    end else if (ra) e_ga = 1;
    else if (rb) e_gb = 1;
    e_wa = ra && !e_ga;
    e_wb = rb && !e_gb;
    if (e_gb) begin
      e_addr = b_bus.addr; e_data = b_bus.writedata; e_wren = b_bus.write;
    end else begin
      e_addr = a_bus.addr; e_data = a_bus.writedata; e_wren = e_ga && a_bus.write;
    end
    if (!rst_n) e_wren = 0;
    e_rva = 0; e_rvb = 0; e_rdata = '0;
    if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) e_rvb = 1; else e_rva = 1;
      e_rdata = pend[0].data;
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
    end else begin
      model_eval();
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
      if (e_gb) begin
        m_last = 1'b1;
        if (b_bus.write) shadow[b_bus.addr] = b_bus.writedata;
        else pend.push_back('{due: cyc + RD_LAT, port: 1'b1, data: shadow[b_bus.addr]});
      end else if (e_ga) begin
        m_last = 1'b0;
        if (a_bus.write) shadow[a_bus.addr] = a_bus.writedata;
        else pend.push_back('{due: cyc + RD_LAT, port: 1'b0, data: shadow[a_bus.addr]});
      end
      if (clr_stats) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else begin
        if (e_ga && m_cnt_a < (1 << CNT_W) - 1) m_cnt_a++;
        if (e_gb && m_cnt_b < (1 << CNT_W) - 1) m_cnt_b++;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    a_bus.read = 0; a_bus.write = 0;
    b_bus.read = 0; b_bus.write = 0;
  endtask

  task automatic drain();
    idle();
    repeat (RD_LAT + 2) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_bus.read = 1; a_bus.write = 1; a_bus.addr = AW'(3); a_bus.writedata = 32'hDEAD_BEEF;
    #1; model_eval();
    n_checks++; if (a_bus.waitrequest !== 1'b0) $display("FAIL rst_a_wait got=%b exp=0", a_bus.waitrequest); else n_pass++;
    n_checks++; if (ram_wren !== 1'b0) $display("FAIL rst_wren got=%b exp=0", ram_wren); else n_pass++;
    n_checks++; if (a_bus.readdatavalid !== 1'b0 || b_bus.readdatavalid !== 1'b0)
      $display("FAIL rst_rdv got=%b%b exp=00", a_bus.readdatavalid, b_bus.readdatavalid); else n_pass++;
    n_checks++; if (cnt_a !== '0 || cnt_b !== '0) $display("FAIL rst_cnt got=%0d/%0d exp=0/0", cnt_a, cnt_b); else n_pass++;
    tick(); tick();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    a_bus.read = 0; a_bus.write = 1; a_bus.addr = AW'(5); a_bus.writedata = 32'h0000_00AB;
    #1; model_eval();
    n_checks++; if (ram_wren !== 1'b1) $display("FAIL wr_wren got=%b exp=1", ram_wren); else n_pass++;
    n_checks++; if (ram_addr !== AW'(5) || ram_data !== 32'hAB)
      $display("FAIL wr_bus got=%h/%h exp=005/000000ab", ram_addr, ram_data); else n_pass++;
    tick();
    a_bus.read = 1; a_bus.write = 0;
    #1; model_eval();
    n_checks++; if (ram_wren !== 1'b0) $display("FAIL rd_wren got=%b exp=0", ram_wren); else n_pass++;
    tick();
    idle();
    for (int i = 1; i <= RD_LAT + 1; i++) begin
      #1; model_eval();
      n_checks++; if (a_bus.readdatavalid !== (i == RD_LAT))
        $display("FAIL wr_rd_valid i=%0d got=%b exp=%b", i, a_bus.readdatavalid, (i == RD_LAT)); else n_pass++;
      if (i == RD_LAT) begin
        n_checks++; if (a_bus.readdata !== 32'h0000_00AB)
          $display("FAIL wr_rd_data got=%h exp=000000ab", a_bus.readdata); else n_pass++;
      end
      n_checks++; if (b_bus.readdatavalid !== 1'b0) $display("FAIL wr_rd_bvalid i=%0d got=1 exp=0", i); else n_pass++;
      tick();
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
    pri_fixed = 0;
    for (int j = 0; j <= 6 + RD_LAT; j++) begin
      if (j < 6) begin
        a_bus.read = 1; a_bus.addr = AW'(j);
        b_bus.read = 1; b_bus.addr = AW'(j + 8);
      end else idle();
      #1; model_eval();
      if (j < 6) begin
        n_checks++; if (a_bus.waitrequest !== (j % 2 == 1) || b_bus.waitrequest !== (j % 2 == 0))
          $display("FAIL rr_grant j=%0d got wait a=%b b=%b", j, a_bus.waitrequest, b_bus.waitrequest); else n_pass++;
      end
      if (j >= RD_LAT) begin
        n_checks++;
        if (a_bus.readdatavalid !== (j - RD_LAT < 6 && (j - RD_LAT) % 2 == 0) ||
            b_bus.readdatavalid !== (j - RD_LAT < 6 && (j - RD_LAT) % 2 == 1))
          $display("FAIL rr_valid j=%0d got a=%b b=%b", j, a_bus.readdatavalid, b_bus.readdatavalid); else n_pass++;
        if (e_rva || e_rvb) begin
          n_checks++; if (ram_q !== e_rdata) $display("FAIL rr_data j=%0d got=%h exp=%h", j, ram_q, e_rdata); else n_pass++;
        end
      end
      tick();
    end
    n_checks++; if (cnt_a !== 4'd3 || cnt_b !== 4'd3) $display("FAIL rr_cnt got=%0d/%0d exp=3/3", cnt_a, cnt_b); else n_pass++;
  endtask

  task automatic test_priority();
    int pa = 0, pb = 0;
    idle(); clr_stats = 1; tick(); clr_stats = 0;
    #1;
    n_checks++; if (cnt_a !== '0 || cnt_b !== '0) $display("FAIL clr_cnt got=%0d/%0d exp=0/0", cnt_a, cnt_b); else n_pass++;
    pri_fixed = 1;
    for (int j = 0; j <= 5 + RD_LAT; j++) begin
      if (j < 5) begin
        a_bus.read = 1; a_bus.addr = AW'(j);
        b_bus.read = 1; b_bus.addr = AW'(j + 32);
      end else idle();
      #1; model_eval();
      if (j < 5) begin
        n_checks++; if (a_bus.waitrequest !== 1'b1 || b_bus.waitrequest !== 1'b0)
          $display("FAIL pri_wait j=%0d got a=%b b=%b exp a=1 b=0", j, a_bus.waitrequest, b_bus.waitrequest); else n_pass++;
      end
      if (a_bus.readdatavalid) pa++;
      if (b_bus.readdatavalid) pb++;
      tick();
    end
    n_checks++; if (pa !== 0 || pb !== 5) $display("FAIL pri_pulses got a=%0d b=%0d exp a=0 b=5", pa, pb); else n_pass++;
    n_checks++; if (cnt_a !== 4'd0 || cnt_b !== 4'd5) $display("FAIL pri_cnt got=%0d/%0d exp=0/5", cnt_a, cnt_b); else n_pass++;
    pri_fixed = 0;
  endtask

  task automatic test_reset_midflight();
    int pa = 0;
    a_bus.read = 1; a_bus.addr = AW'(1);
    #1; tick();
    a_bus.addr = AW'(2);
    #1;
    @(posedge clk); model_commit();
    #1; idle(); rst_n = 1'b0; model_reset();
    #1;
    n_checks++; if (a_bus.readdatavalid !== 1'b0) $display("FAIL mid_rst_valid got=1 exp=0"); else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < RD_LAT + 3; j++) begin
      #1; if (a_bus.readdatavalid) pa++;
      tick();
    end
    n_checks++; if (pa !== 0) $display("FAIL mid_stale_valid got=%0d exp=0", pa); else n_pass++;
    n_checks++; if (cnt_a !== '0 || cnt_b !== '0) $display("FAIL mid_cnt got=%0d/%0d exp=0/0", cnt_a, cnt_b); else n_pass++;
    a_bus.read = 1; a_bus.addr = AW'(1);
    b_bus.read = 1; b_bus.addr = AW'(2);
    #1;
    n_checks++; if (a_bus.waitrequest !== 1'b0 || b_bus.waitrequest !== 1'b1)
      $display("FAIL mid_first_tie got wait a=%b b=%b exp a=0 b=1", a_bus.waitrequest, b_bus.waitrequest); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_saturation();
    idle(); clr_stats = 1; tick(); clr_stats = 0;
    for (int j = 0; j < 20; j++) begin
      a_bus.read = 1; a_bus.addr = AW'(j % 16);
      #1; model_eval();
      n_checks++; if (a_bus.readdatavalid !== e_rva) $display("FAIL sat_valid j=%0d got=%b exp=%b", j, a_bus.readdatavalid, e_rva); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (cnt_a !== 4'hF) $display("FAIL sat_cnt got=%0d exp=15", cnt_a); else n_pass++;
    clr_stats = 1;
    tick();
    clr_stats = 0;
    #1;
    n_checks++; if (cnt_a !== 4'h0) $display("FAIL sat_clr got=%0d exp=0", cnt_a); else n_pass++;
    drain();
  endtask

  task automatic test_rw_both();
    int pb = 0;
    b_bus.read = 1; b_bus.write = 1; b_bus.addr = AW'(12'h010); b_bus.writedata = 32'h0000_1234;
    #1;
    n_checks++; if (ram_wren !== 1'b1 || ram_addr !== AW'(12'h010) || ram_data !== 32'h1234)
      $display("FAIL rw_bus got wren=%b addr=%h data=%h", ram_wren, ram_addr, ram_data); else n_pass++;
    tick();
    idle();
    for (int j = 0; j < RD_LAT + 2; j++) begin
      #1; if (b_bus.readdatavalid) pb++;
      tick();
    end
    n_checks++; if (pb !== 0) $display("FAIL rw_no_valid got=%0d exp=0", pb); else n_pass++;
    b_bus.read = 1; b_bus.addr = AW'(12'h010);
    #1; tick();
    idle();
    for (int i = 1; i <= RD_LAT + 1; i++) begin
      #1;
      n_checks++; if (b_bus.readdatavalid !== (i == RD_LAT))
        $display("FAIL rw_rd_valid i=%0d got=%b", i, b_bus.readdatavalid); else n_pass++;
      if (i == RD_LAT) begin
        n_checks++; if (b_bus.readdata !== 32'h0000_1234) $display("FAIL rw_rd_data got=%h exp=00001234", b_bus.readdata); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit hold_a = 0, hold_b = 0;
    for (int k = 0; k < 400; k++) begin
      if (!hold_a) begin
        a_bus.read = 1'($urandom_range(0, 1)); a_bus.write = ($urandom_range(0, 3) == 0);
        a_bus.addr = AW'($urandom_range(0, 15)); a_bus.writedata = $urandom;
      end
      if (!hold_b) begin
        b_bus.read = 1'($urandom_range(0, 1)); b_bus.write = ($urandom_range(0, 3) == 0);
        b_bus.addr = AW'($urandom_range(0, 15)); b_bus.writedata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) pri_fixed = ~pri_fixed;
      clr_stats = ($urandom_range(0, 31) == 0);
      #1; model_eval();
      n_checks++; if (a_bus.waitrequest !== e_wa || b_bus.waitrequest !== e_wb)
        $display("FAIL rnd_wait k=%0d got a=%b b=%b exp a=%b b=%b", k, a_bus.waitrequest, b_bus.waitrequest, e_wa, e_wb); else n_pass++;
      n_checks++; if (ram_wren !== e_wren || ram_addr !== e_addr || (e_wren && ram_data !== e_data))
        $display("FAIL rnd_ram k=%0d got %b/%h/%h exp %b/%h/%h", k, ram_wren, ram_addr, ram_data, e_wren, e_addr, e_data); else n_pass++;
      n_checks++; if (a_bus.readdatavalid !== e_rva || b_bus.readdatavalid !== e_rvb)
        $display("FAIL rnd_valid k=%0d got a=%b b=%b exp a=%b b=%b", k, a_bus.readdatavalid, b_bus.readdatavalid, e_rva, e_rvb); else n_pass++;
      if (e_rva || e_rvb) begin
        n_checks++; if (a_bus.readdata !== e_rdata) $display("FAIL rnd_data k=%0d got=%h exp=%h", k, a_bus.readdata, e_rdata); else n_pass++;
      end
      n_checks++; if (cnt_a !== CNT_W'(m_cnt_a) || cnt_b !== CNT_W'(m_cnt_b))
        $display("FAIL rnd_cnt k=%0d got=%0d/%0d exp=%0d/%0d", k, cnt_a, cnt_b, m_cnt_a, m_cnt_b); else n_pass++;
      hold_a = e_wa;
      hold_b = e_wb;
      tick();
    end
    clr_stats = 0;
    drain();
  endtask

  initial begin
    rst_n = 1'b0; pri_fixed = 1'b0; clr_stats = 1'b0; cyc = 0;
    a_bus.addr = '0; a_bus.writedata = '0; b_bus.addr = '0; b_bus.writedata = '0;
    idle();
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_round_robin();
    test_priority();
    test_reset_midflight();
    test_saturation();
    test_rw_both();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
